// File: rtl/ifu_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit: default geometry,
// reset vector and the instruction-queue entry layout.
package ifu_prefetch_pkg;

  localparam int unsigned IFU_XLEN     = 32;
  localparam int unsigned IFU_DEPTH    = 4;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [IFU_XLEN-1:0] pc;
    logic [31:0]         inst;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with occupancy count and flush; head word is read straight
// from storage, so a pushed entry becomes visible the cycle after the push.
module ifu_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: issues sequential word fetches, tags them with their
// PC, queues in-order responses for decode and discards responses made stale by
// a redirect.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned     XLEN     = IFU_XLEN,
  parameter int unsigned     DEPTH    = IFU_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   live_q, live_d;
  logic [CW-1:0]   stale_q, stale_d;

  logic            accept;
  logic            rsp_live;
  logic [CW:0]     occ_sum, flight_sum;

  logic [XLEN+31:0] iq_din, iq_dout;
  logic [CW-1:0]    iq_cnt;
  logic             iq_full, iq_empty, iq_pop;

  logic [XLEN-1:0]  tag_head;
  logic [CW-1:0]    tag_cnt;
  logic             tag_full, tag_empty;

  logic             unused_bits;
  assign unused_bits = ^{tag_cnt, tag_full, tag_empty, iq_full, redirect_pc[1:0]};

  // Queued plus live bounds queue space; live plus stale bounds outstanding
  // requests so back-to-back redirects never overrun the counters.
  assign occ_sum    = {1'b0, iq_cnt} + {1'b0, live_q};
  assign flight_sum = {1'b0, live_q} + {1'b0, stale_q};

  assign mem_req_valid = rst_n && !redirect
                         && (occ_sum < (CW+1)'(DEPTH))
                         && (flight_sum < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc_q;
  assign accept        = mem_req_valid && mem_req_ready;

  // A response is kept only when nothing older is still owed to a flushed
  // stream and no redirect is flushing this cycle.
  assign rsp_live = mem_rsp_valid && !redirect && (stale_q == '0);

  assign iq_din     = {tag_head, mem_rsp_data};
  assign iq_pop     = inst_valid && inst_ready;
  assign inst_valid = !iq_empty;
  assign {inst_pc, inst} = iq_dout;

  ifu_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect),
    .push_i  (accept),
    .data_i  (fetch_pc_q),
    .pop_i   (rsp_live),
    .data_o  (tag_head),
    .count_o (tag_cnt),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  ifu_fifo #(.WIDTH(XLEN+32), .DEPTH(DEPTH)) u_inst_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect),
    .push_i  (rsp_live),
    .data_i  (iq_din),
    .pop_i   (iq_pop),
    .data_o  (iq_dout),
    .count_o (iq_cnt),
    .full_o  (iq_full),
    .empty_o (iq_empty)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    live_d     = live_q;
    stale_d    = stale_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      live_d     = '0;
      stale_d    = stale_q + live_q - CW'(mem_rsp_valid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
      live_d = live_q + CW'(accept) - CW'(rsp_live);
      if (mem_rsp_valid && (stale_q != '0)) stale_d = stale_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      live_q     <= '0;
      stale_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      live_q     <= live_d;
      stale_q    <= stale_d;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with an in-order, optionally stalling memory.
module tb_ifu_prefetch;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk;
  logic            rst_n;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  int passed = 0;
  int total  = 0;

  logic        rsp_en;
  logic [31:0] pend[$];

  ifu_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h8000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory: answers in order, earliest in the cycle right after acceptance.
  always @(posedge clk) begin
    if (!rst_n) begin
      pend.delete();
      mem_rsp_valid <= 1'b0;
      mem_rsp_data  <= '0;
    end else begin
      if (mem_req_valid && mem_req_ready) pend.push_back(mem_req_addr);
      if (rsp_en && pend.size() != 0) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data  <= fdata(pend.pop_front());
      end else begin
        mem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b1; inst_ready = 1'b0; rsp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b1; inst_ready = 1'b0; rsp_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", mem_req_valid);
    else passed++;
    total++;
    if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %b want 0", inst_valid);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (mem_req_valid !== 1'b1) $display("FAIL first_req_valid: got %b want 1", mem_req_valid);
    else passed++;
    total++;
    if (mem_req_addr !== 32'h8000_0000) $display("FAIL first_req_addr: got %h want 80000000", mem_req_addr);
    else passed++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_a [4] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
    logic [31:0] addrs [4];
    logic [31:0] pcs [4];
    logic [31:0] dats [4];
    int na = 0;
    int np = 0;
    do_reset();
    inst_ready = 1'b1;
    for (int c = 0; c < 30 && (na < 4 || np < 4); c++) begin
      if (mem_req_valid && mem_req_ready && na < 4) begin addrs[na] = mem_req_addr; na++; end
      if (inst_valid && np < 4) begin pcs[np] = inst_pc; dats[np] = inst; np++; end
      @(negedge clk); #1;
    end
    total++;
    if (na != 4 || np != 4) $display("FAIL seq_timeout: got %0d req %0d inst want 4 4", na, np);
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (addrs[i] !== exp_a[i]) $display("FAIL seq_addr%0d: got %h want %h", i, addrs[i], exp_a[i]);
        else passed++;
        total++;
        if (pcs[i] !== exp_a[i]) $display("FAIL seq_pc%0d: got %h want %h", i, pcs[i], exp_a[i]);
        else passed++;
        total++;
        if (dats[i] !== fdata(exp_a[i])) $display("FAIL seq_inst%0d: got %h want %h", i, dats[i], fdata(exp_a[i]));
        else passed++;
      end
    end
  endtask

  task automatic test_full();
    int acc = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (mem_req_valid && mem_req_ready) acc++;
      @(negedge clk); #1;
    end
    total++;
    if (acc != 4) $display("FAIL full_accepts: got %0d want 4", acc);
    else passed++;
    total++;
    if (mem_req_valid !== 1'b0) $display("FAIL full_req_valid: got %b want 0", mem_req_valid);
    else passed++;
    total++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0000)
      $display("FAIL full_head: got %b/%h want 1/80000000", inst_valid, inst_pc);
    else passed++;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    #1;
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0010)
      $display("FAIL full_after_pop: got %b/%h want 1/80000010", mem_req_valid, mem_req_addr);
    else passed++;
    total++;
    if (inst_pc !== 32'h8000_0004) $display("FAIL full_next_head: got %h want 80000004", inst_pc);
    else passed++;
  endtask

  task automatic wait_first_inst(input string name, input logic [31:0] exp_pc);
    bit found = 0;
    for (int c = 0; c < 25 && !found; c++) begin
      if (inst_valid === 1'b1) found = 1;
      else begin @(negedge clk); #1; end
    end
    total++;
    if (!found) $display("FAIL %s_timeout: got no inst want pc %h", name, exp_pc);
    else if (inst_pc !== exp_pc || inst !== fdata(exp_pc))
      $display("FAIL %s_first: got %h/%h want %h/%h", name, inst_pc, inst, exp_pc, fdata(exp_pc));
    else passed++;
  endtask

  task automatic test_redirect_stale();
    do_reset();
    rsp_en = 1'b0;
    inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_1002;
    #1;
    total++;
    if (mem_req_valid !== 1'b0) $display("FAIL redir_req_valid: got %b want 0", mem_req_valid);
    else passed++;
    @(negedge clk);
    redirect = 1'b0;
    rsp_en = 1'b1;
    #1;
    total++;
    if (inst_valid !== 1'b0) $display("FAIL redir_inst_valid: got %b want 0", inst_valid);
    else passed++;
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1000)
      $display("FAIL redir_req: got %b/%h want 1/00001000", mem_req_valid, mem_req_addr);
    else passed++;
    wait_first_inst("redir", 32'h0000_1000);
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    inst_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_2000;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    total++;
    if (inst_valid !== 1'b0) $display("FAIL rsp_redir_inst_valid: got %b want 0", inst_valid);
    else passed++;
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_2000)
      $display("FAIL rsp_redir_req: got %b/%h want 1/00002000", mem_req_valid, mem_req_addr);
    else passed++;
    wait_first_inst("rsp_redir", 32'h0000_2000);
  endtask

  task automatic test_wrap();
    logic [31:0] addrs [2];
    logic [31:0] pcs [2];
    int na = 0;
    int np = 0;
    do_reset();
    inst_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    for (int c = 0; c < 20 && (na < 2 || np < 2); c++) begin
      if (mem_req_valid && mem_req_ready && na < 2) begin addrs[na] = mem_req_addr; na++; end
      if (inst_valid && np < 2) begin pcs[np] = inst_pc; np++; end
      @(negedge clk); #1;
    end
    total++;
    if (na != 2 || np != 2) $display("FAIL wrap_timeout: got %0d req %0d inst want 2 2", na, np);
    else if (addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0000_0000)
      $display("FAIL wrap_addr: got %h %h want fffffffc 00000000", addrs[0], addrs[1]);
    else passed++;
    total++;
    if (np == 2 && (pcs[0] !== 32'hFFFF_FFFC || pcs[1] !== 32'h0000_0000))
      $display("FAIL wrap_pc: got %h %h want fffffffc 00000000", pcs[0], pcs[1]);
    else if (np != 2) $display("FAIL wrap_pc_count: got %0d want 2", np);
    else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    mem_req_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000)
        $display("FAIL stall_hold%0d: got %b/%h want 1/80000000", c, mem_req_valid, mem_req_addr);
      else passed++;
      @(negedge clk); #1;
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    total++;
    if (mem_req_addr !== 32'h8000_0004) $display("FAIL stall_advance: got %h want 80000004", mem_req_addr);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    rsp_en = 1'b0;
    inst_ready = 1'b1;
    repeat (2) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_4000;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_4000)
      $display("FAIL b2b_req1: got %b/%h want 1/00004000", mem_req_valid, mem_req_addr);
    else passed++;
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_5000;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_5000)
      $display("FAIL b2b_req2: got %b/%h want 1/00005000", mem_req_valid, mem_req_addr);
    else passed++;
    @(negedge clk); #1;
    total++;
    if (mem_req_valid !== 1'b0) $display("FAIL b2b_limit: got %b want 0", mem_req_valid);
    else passed++;
    rsp_en = 1'b1;
    wait_first_inst("b2b", 32'h0000_5000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_redirect_stale();
    test_redirect_rsp();
    test_wrap();
    test_stall();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/PC width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction-queue depth and maximum in-flight fetches; power of two, >=2.
REQ-003 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning first fetch address after reset.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  XLEN  fetch address, word aligned.
- mem_rsp_valid  in  1  response valid; in order, one per accepted request, no backpressure.
- mem_rsp_data  in  32  fetched instruction word.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode consumes head.
- inst  out  32  head instruction.
- inst_pc  out  XLEN  head PC.
- redirect  in  1  branch/jump/trap flush.
- redirect_pc  in  XLEN  new fetch PC; bits[1:0] ignored.

Function
REQ-005 SHALL hold fetch_pc; request accepted when mem_req_valid && mem_req_ready; fetch_pc += 4 on acceptance, wrapping mod 2^XLEN.
REQ-006 SHALL drive mem_req_valid = 1 only when (queue count + live outstanding) < DEPTH and redirect = 0.
REQ-007 SHALL keep mem_req_addr stable while mem_req_valid && !mem_req_ready.
REQ-008 SHALL track live count (0..DEPTH) and stale count (0..DEPTH) of outstanding requests.
REQ-009 SHALL, on mem_rsp_valid with stale > 0, discard response and decrement stale; else push {pc, data} into queue and decrement live.
REQ-010 SHALL record per-request PC in an in-order PC tag queue so pushed PC equals the request address.
REQ-011 SHALL present pushed entry at inst/inst_valid in the cycle after mem_rsp_valid (one-cycle registered latency, no bypass).
REQ-012 SHALL pop head when inst_valid && inst_ready; simultaneous push and pop on a full queue SHALL be legal.
REQ-013 SHALL, on redirect = 1: empty queue next cycle, move live+in-flight count into stale, set fetch_pc = {redirect_pc[XLEN-1:2],2'b00}, issue no request that cycle.
REQ-014 SHALL treat a response arriving in the redirect cycle as stale (discarded).
REQ-015 SHALL hold inst_valid = 0 in the cycle after redirect; first post-redirect request issued the cycle after redirect.
REQ-016 SHALL ignore inst_ready when inst_valid = 0.
REQ-017 SHALL accumulate stale counts across back-to-back redirects without overflow (live + stale <= DEPTH invariant).

Reset
REQ-018 SHALL, while rst_n = 0 at a clock edge: fetch_pc = RESET_PC, queue empty, live = stale = 0, mem_req_valid = 0, inst_valid = 0.
REQ-019 SHALL output mem_req_valid = 1 with mem_req_addr = RESET_PC in the first cycle after rst_n rises.
REQ-020 SHALL drop any in-flight responses across reset; memory is reset by the same rst_n.

Structure
REQ-021 SHALL place XLEN/DEPTH/RESET_PC defaults and the queue entry struct {pc, inst} in the shared core package.
REQ-022 SHALL instantiate one sub-module, ifu_fifo: parametrised synchronous FIFO (width, depth) with count, full, empty, flush; used for instruction queue and PC tag queue.

Verification
REQ-023 Reset release, mem_req_ready = 1, 1-cycle memory -> addresses 0x8000_0000, _0004, _0008, _000C issued; inst_pc matches in order.
REQ-024 inst_ready = 0, memory always ready -> exactly DEPTH (4) requests accepted, then mem_req_valid = 0 until one pop.
REQ-025 Redirect to 0x0000_1002 with 3 outstanding -> 3 responses discarded; next inst_pc = 0x0000_1000.
REQ-026 Redirect in the same cycle as mem_rsp_valid -> that response never appears on inst.
REQ-027 fetch_pc = 0xFFFF_FFFC accepted -> next request address 0x0000_0000.
REQ-028 mem_req_ready held 0 for 5 cycles -> mem_req_addr constant; single acceptance advances fetch_pc by 4.
